log20_pipe: RTL and testbench
=============================

Name: log20_pipe

Overview:
- Pipelined linear-to-log2 converter (Mitchell approximation). It is the forward counterpart of the existing antilog block.
- Takes an unsigned 20-bit magnitude in (1,19) fixed point plus a sign bit. Produces a signed 19-bit log2 value: 7-bit two's-complement integer, 12-bit fraction.
- Feeds the log-domain multiplier datapath of the LUT-less functional-link filter. The output code round-trips exactly through the antilog block for all in-range values (truncation only).

Parameters:
- W_LIN, 20, input magnitude width, (1,19) format.
- W_INT, 7, log integer (exponent) width, two's complement.
- W_FRAC, 12, log fraction width.
- Only the defaults are supported and verified. Other values are a synthesis-time error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  20  unsigned magnitude, (1,19).
- in_sign  in  1  sign of the linear value, passed through unchanged.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_log  out  19  {exponent[6:0], fraction[11:0]}.
- out_sign  out  1  delayed in_sign.
- out_zero  out  1  input magnitude was zero.

Behaviour:
- Reset values: out_valid=0, out_log=0, out_sign=0, out_zero=0. All stage valids clear. in_ready is 1 in the cycle after rst deasserts.
- Handshake: transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready. Standard valid/ready: valid must not depend on ready.
- Pipeline: 3 stages, global advance adv = !v3 || out_ready. in_ready = adv. Stages shift together only on adv; bubbles are not collapsed.
- Latency: exactly 3 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 sample per cycle.
- S1: register in_data and in_sign. Compute the leading-one position p (19..0) combinationally; zero flag = (in_data==0).
- S2: register p, zero, sign. Left-shift the magnitude by (19-p) so the leading one sits at bit 19. Take bits [18:7] as the fraction. Bits below the window are truncated, never rounded. If fewer than 12 bits follow the leading one, zeros are shifted in.
- S3: register the output.
  - exponent = p-19, range -19..0, two's complement in 7 bits. Examples: p=19 gives 7'h00; p=0 gives 7'h6D.
  - zero input: out_log = LOG_ZERO (19'h40000, i.e. -64.0) and out_zero=1. The antilog block maps this to 0.
- Stall: while out_valid&&!out_ready, all stage registers hold and in_ready=0. No sample is lost or duplicated, and order is preserved.
- Simultaneous in and out transfer in the same cycle with a full pipeline is legal and sustains full rate.
- rst mid-stream discards all in-flight samples. The next cycle behaves as after power-up reset.
- No X propagation: registers are loaded only under valid; data-path registers may hold stale values when invalid.

Decomposition:
- Shared package log_pkg:
  - W_LIN, W_INT, W_FRAC.
  - LOG_ZERO = 19'h40000.
  - EXP_MIN = -19.
  - Typedef for the 19-bit log word.
  - The antilog block and the multiplier use the same package.
- Sub-module lod20: combinational 20-bit leading-one detector. Output is a 5-bit position plus a zero flag. It is instantiated in S1 and unit-tested separately.

Test Plan:
- Exponent 0, fraction 0: in_data 20'h80000 → 3 cycles later out_log 19'h00000, out_zero=0.
- Exponent -1 and fraction extraction:
  - 20'h40000 → 19'h7F000.
  - 20'hC0000 → 19'h00800.
  - 20'hFFFFF → 19'h00FFF (truncation).
- Low-end boundary:
  - 20'h00001 → 19'h6D000.
  - 20'h00003 → 19'h6E800 (zero-filled fraction).
  - 20'h00000 → 19'h40000 with out_zero=1.
  - in_sign=1 appears on out_sign with the matching sample.
- Back-pressure: stream 8 samples back-to-back, hold out_ready=0 for 5 cycles mid-stream → in_ready falls after the pipe fills. All 8 outputs appear in order, none duplicated. Full rate resumes with 1-cycle recovery.
- Reset mid-stream: assert rst with 3 samples in flight → no out_valid after reset until new inputs arrive; first new output arrives 3 cycles after acceptance.
- Round-trip sweep: random 10k magnitudes through log20_pipe then the antilog block → result equals the input with bits below the 13-bit window cleared; zero maps to zero.

Source files
------------

// File: rtl/log_pkg.sv
// log_pkg: shared definitions for the log-domain datapath (log20_pipe,
// antilog block, log-domain multiplier).
//   W_LIN    linear magnitude width, unsigned (1,19)
//   W_INT    log integer (exponent) width, two's complement
//   W_FRAC   log fraction width
//   LOG_ZERO code for a zero magnitude (-64.0), mapped back to 0 by antilog
package log_pkg;

  localparam int W_LIN   = 20;
  localparam int W_INT   = 7;
  localparam int W_FRAC  = 12;
  localparam int W_LOG   = W_INT + W_FRAC;
  localparam int EXP_MIN = -19;

  typedef logic [W_LOG-1:0] log_word_t;

  localparam log_word_t LOG_ZERO = 19'h40000;

  // Exponent of a normalised magnitude whose leading one sits at bit p:
  // p - 19, i.e. 0 down to -19 in two's complement.
  function automatic logic [W_INT-1:0] exp_from_pos(input logic [4:0] p);
    return {2'b00, p} - 7'd19;
  endfunction

  // Fraction window: move the leading one up to bit 19 and keep the next
  // 12 bits. Anything below the window is dropped (truncation); zeros
  // enter from the bottom when fewer than 12 bits follow the leading one.
  function automatic logic [W_FRAC-1:0] frac_window(input logic [W_LIN-1:0] mag,
                                                     input logic [4:0]       p);
    logic [W_LIN-1:0] norm;
    norm = mag << (5'd19 - p);
    return norm[18:7];
  endfunction

endpackage

// File: rtl/log20_pipe_if.sv
// log20_pipe_if: valid/ready bundle around the linear-to-log converter.
//   in_valid/in_ready/in_data/in_sign          sample input side
//   out_valid/out_ready/out_log/out_sign/out_zero  log result side
// master = producer of samples / consumer of results, slave = converter.
interface log20_pipe_if;
  import log_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W_LIN-1:0] in_data;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  log_word_t        out_log;
  logic             out_sign;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_sign, out_ready,
    input  in_ready, out_valid, out_log, out_sign, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_sign, out_ready,
    output in_ready, out_valid, out_log, out_sign, out_zero
  );

endinterface

// File: rtl/lod20.sv
// lod20: combinational 20-bit leading-one detector.
//   din   magnitude to scan
//   pos   bit index (19..0) of the most significant one; 0 when din is 0
//   zero  din is all zeros
module lod20
  import log_pkg::*;
(
  input  logic [W_LIN-1:0] din,
  output logic [4:0]       pos,
  output logic             zero
);

  logic [4:0] pos_s;

  // Priority scan from LSB upward: the last one seen is the highest.
  always_comb begin
    pos_s = 5'd0;
    for (int i = 0; i < W_LIN; i++) begin
      if (din[i]) begin
        pos_s = 5'(i);
      end else begin
        pos_s = pos_s;
      end
    end
  end

  assign pos  = pos_s;
  assign zero = (din == {W_LIN{1'b0}});

endmodule

// File: rtl/log20_pipe.sv
// log20_pipe: 3-stage pipelined linear-to-log2 converter (Mitchell).
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  log20_pipe_if.slave:
//        in_valid/in_ready/in_data(1,19)/in_sign   accepted sample
//        out_valid/out_ready/out_log{exp[6:0],frac[11:0]}/out_sign/out_zero
// All stages advance together on adv = !v3 || out_ready; bubbles are kept.
module log20_pipe #(
  parameter int W_LIN  = log_pkg::W_LIN,
  parameter int W_INT  = log_pkg::W_INT,
  parameter int W_FRAC = log_pkg::W_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  log20_pipe_if.slave       bus
);

  // Only the package widths are implemented.
  if (W_LIN != log_pkg::W_LIN || W_INT != log_pkg::W_INT ||
      W_FRAC != log_pkg::W_FRAC) begin : g_param_check
    $error("log20_pipe: only W_LIN=20, W_INT=7, W_FRAC=12 are supported");
  end

  localparam int WL = log_pkg::W_LIN;
  localparam int WI = log_pkg::W_INT;
  localparam int WF = log_pkg::W_FRAC;

  logic                adv_s;

  // Stage 1
  logic                v1_r;
  logic [WL-1:0]       d1_r;
  logic                s1_r;
  logic [4:0]          pos1_s;
  logic                zero1_s;

  // Stage 2
  logic                v2_r;
  logic [WL-1:0]       d2_r;
  logic [4:0]          p2_r;
  logic                z2_r;
  logic                s2_r;
  logic [WI-1:0]       exp2_s;
  logic [WF-1:0]       frac2_s;
  log_pkg::log_word_t  log2_s;

  // Stage 3 (output registers)
  logic                v3_r;
  log_pkg::log_word_t  log3_r;
  logic                s3_r;
  logic                z3_r;

  assign adv_s       = !v3_r || bus.out_ready;
  assign bus.in_ready = adv_s;

  // Stage 1: capture the accepted magnitude and sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0;
      d1_r <= {WL{1'b0}};
      s1_r <= 1'b0;
    end else if (adv_s) begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        d1_r <= bus.in_data;
        s1_r <= bus.in_sign;
      end
    end
  end

  lod20 u_lod20 (
    .din  (d1_r),
    .pos  (pos1_s),
    .zero (zero1_s)
  );

  // Stage 2: hold leading-one position, zero flag, sign and magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r <= 1'b0;
      d2_r <= {WL{1'b0}};
      p2_r <= 5'd0;
      z2_r <= 1'b0;
      s2_r <= 1'b0;
    end else if (adv_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        d2_r <= d1_r;
        p2_r <= pos1_s;
        z2_r <= zero1_s;
        s2_r <= s1_r;
      end
    end
  end

  // Normalise and form the log word; zero magnitude gets the reserved code.
  always_comb begin
    exp2_s  = log_pkg::exp_from_pos(p2_r);
    frac2_s = log_pkg::frac_window(d2_r, p2_r);
    if (z2_r) begin
      log2_s = log_pkg::LOG_ZERO;
    end else begin
      log2_s = {exp2_s, frac2_s};
    end
  end

  // Stage 3: output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r   <= 1'b0;
      log3_r <= {(WI + WF){1'b0}};
      s3_r   <= 1'b0;
      z3_r   <= 1'b0;
    end else if (adv_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        log3_r <= log2_s;
        s3_r   <= s2_r;
        z3_r   <= z2_r;
      end
    end
  end

  assign bus.out_valid = v3_r;
  assign bus.out_log   = log3_r;
  assign bus.out_sign  = s3_r;
  assign bus.out_zero  = z3_r;

endmodule

// File: tb/tb_log20_pipe.sv
// tb_log20_pipe: directed + random scoreboard bench for log20_pipe.
module tb_log20_pipe;

  logic clk;
  logic rst;

  log20_pipe_if bus ();

  log20_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] log;
    logic        sign;
    logic        zero;
    logic [19:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   out_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int msb_pos(input logic [19:0] d);
    int p;
    p = -1;
    for (int b = 19; b >= 0; b--) begin
      if (d[b] && p < 0) p = b;
    end
    return p;
  endfunction

  // Reference: exponent p-19, fraction = the 12 bits following the leading one.
  function automatic exp_t model(input logic [19:0] d, input logic s);
    exp_t m;
    int p;
    int idx;
    logic [6:0] ex;
    logic [11:0] fr;
    p = msb_pos(d);
    m.data = d;
    m.sign = s;
    if (p < 0) begin
      m.zero = 1'b1;
      m.log  = 19'h40000;
    end else begin
      ex = 7'(p - 19);
      for (int k = 0; k < 12; k++) begin
        idx = p - 1 - k;
        fr[11-k] = (idx >= 0) ? d[idx] : 1'b0;
      end
      m.zero = 1'b0;
      m.log  = {ex, fr};
    end
    return m;
  endfunction

  // Antilog of a log word back to (1,19).
  function automatic logic [19:0] antilog(input logic [18:0] lw, input logic z);
    logic signed [6:0] e;
    logic [19:0] mant;
    if (z) return 20'd0;
    e = lw[18:12];
    mant = {1'b1, lw[11:0], 7'b0};
    return mant >> (-int'(e));
  endfunction

  // Input with every bit below the 13-bit window (leading one + 12) cleared.
  function automatic logic [19:0] trunc13(input logic [19:0] d);
    int p;
    logic [19:0] r;
    p = msb_pos(d);
    r = d;
    for (int b = 0; b < 20; b++) begin
      if (p >= 0 && b < p - 12) r[b] = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_log", 32'(bus.out_log), 32'(mon_e.log));
          chk("sb_sign", 32'(bus.out_sign), 32'(mon_e.sign));
          chk("sb_zero", 32'(bus.out_zero), 32'(mon_e.zero));
          chk("roundtrip", 32'(antilog(bus.out_log, bus.out_zero)), 32'(trunc13(mon_e.data)));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_data, bus.in_sign));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] d, input logic s);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sign  = s;
    for (int w = 0; w < 100 && !acc; w++) begin
      #1;
      acc = bus.in_ready;
      step();
    end
    chk("send_accept", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [19:0] d, input logic s,
                         input logic [18:0] exp_log, input logic exp_zero);
    int lat;
    bus.out_ready = 1'b1;
    send(d, s);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    chk("dir_log", 32'(bus.out_log), 32'(exp_log));
    chk("dir_zero", 32'(bus.out_zero), 32'(exp_zero));
    chk("dir_sign", 32'(bus.out_sign), 32'(s));
    step();
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 50 && (sb.size() != 0 || bus.out_valid); w++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    logic seen;
    int   idx;
    int   n;
    int   cyc;
    int   cnt0;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 20'd0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_log", 32'(bus.out_log), 32'd0);
    chk("rst_out_sign", 32'(bus.out_sign), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Directed vectors
    run_one(20'h80000, 1'b0, 19'h00000, 1'b0);
    run_one(20'h40000, 1'b0, 19'h7F000, 1'b0);
    run_one(20'hC0000, 1'b1, 19'h00800, 1'b0);
    run_one(20'hFFFFF, 1'b0, 19'h00FFF, 1'b0);
    run_one(20'h00001, 1'b1, 19'h6D000, 1'b0);
    run_one(20'h00003, 1'b0, 19'h6E800, 1'b0);
    run_one(20'h00000, 1'b1, 19'h40000, 1'b1);

    // Back-pressure: 8 back-to-back samples, out_ready low for cycles 5..9
    cnt0 = out_cnt;
    idx  = 0;
    for (int c = 0; c < 30; c++) begin
      bus.out_ready = !(c >= 5 && c < 10);
      if (idx < 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 20'(32'h12345 * (idx + 1));
        bus.in_sign  = idx[0];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c == 7) begin
        chk("bp_in_ready_stall", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
      end
      if (c == 10) chk("bp_in_ready_resume", 32'(bus.in_ready), 32'd1);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd8);
    drain();
    chk("bp_out_count", 32'(out_cnt - cnt0), 32'd8);

    // Reset with 3 samples in flight
    bus.out_ready = 1'b1;
    send(20'h11111, 1'b0);
    send(20'h22222, 1'b1);
    send(20'h33333, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seen = seen | bus.out_valid;
      step();
    end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);
    run_one(20'h2ABCD, 1'b1, 19'h7E55E, 1'b0);

    // Random sweep with random back-pressure
    n   = 0;
    cyc = 0;
    while (n < 10000 && cyc < 40000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 7) != 0);
      bus.in_data   = 20'($urandom) >> $urandom_range(0, 20);
      bus.in_sign   = 1'($urandom);
      #1;
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) n++;
      cyc++;
    end
    chk("sweep_count", 32'(n), 32'd10000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
